fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries, power of two, >=2.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 n_reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  instruction memory accepts request.
REQ-007 imem_req_addr  output  32  fetch address, word aligned.
REQ-008 imem_rsp_valid  input  1  in-order response, latency >=1 cycle, never back-pressured.
REQ-009 imem_rsp_data  input  32  fetched instruction word.
REQ-010 instr_valid  output  1  instruction available to cpu.
REQ-011 instr_ready  input  1  cpu consumes instruction.
REQ-012 instr  output  32  instruction word to cpu.
REQ-013 instr_pc  output  32  address of instr.
REQ-014 redirect  input  1  branch/jump taken, one-cycle pulse.
REQ-015 redirect_pc  input  32  new fetch target.
REQ-016 fault  output  1  misaligned redirect target (FETCH_MISALIGN_CHECK_EN only).

Function
REQ-017 Request handshake SHALL complete when imem_req_valid && imem_req_ready; imem_req_addr then advances by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-018 imem_req_valid SHALL be asserted only while outstanding + buffered < BUF_DEPTH (credit rule); buffer never overflows.
REQ-019 Outstanding counter SHALL increment on request handshake, decrement on imem_rsp_valid; simultaneous events leave it unchanged.
REQ-020 Valid responses SHALL be written to the FIFO with their PC (tracked in a parallel PC FIFO/counter); instr_valid SHALL be high whenever the FIFO is non-empty.
REQ-021 Delivery handshake SHALL complete when instr_valid && instr_ready; FIFO head pops same edge; empty FIFO SHALL NOT bypass a same-cycle response (minimum fetch-to-instr latency: response cycle + 1).
REQ-022 instr/instr_pc SHALL hold stable while instr_valid && !instr_ready.
REQ-023 FIFO full and push+pop same cycle SHALL both be legal; full+pop+push keeps occupancy.
REQ-024 On redirect the FIFO SHALL flush, next imem_req_addr SHALL be redirect_pc, and a drop counter SHALL be loaded with the in-flight count (minus any response arriving that cycle).
REQ-025 Responses arriving while drop counter > 0 SHALL be discarded and decrement it; they consume credit normally.
REQ-026 Redirect coinciding with a delivery handshake: delivery counts as consumed, flush still applies; coinciding with a request handshake: that request counts as in-flight and is dropped.
REQ-027 State machine: RESET -> RUN on first clock after n_reset deasserts; RUN -> RUN on redirect; RUN -> FAULT on misaligned redirect (macro on); FAULT exits only by reset.

Reset
REQ-028 While n_reset low: imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, fault=0, counters=0, FIFO empty, imem_req_addr=RESET_PC.
REQ-029 Reset asserted mid-operation SHALL abandon in-flight requests; memory is reset by the same signal.

Configuration
REQ-030 FETCH_MISALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 sets fault (sticky), enters FAULT, deasserts imem_req_valid and instr_valid.
REQ-031 FETCH_MISALIGN_CHECK_EN undefined: fault port absent, redirect_pc[1:0] ignored (forced to 0), no FAULT state.

Structure
REQ-032 Shared package SHALL hold the state enum (RESET, RUN, FAULT), the 32-bit word typedef and the PC increment constant 4.
REQ-033 FIFO SHALL be a separate sub-module fetch_fifo (parameterised depth/width, push/pop/full/empty/flush).

Verification
REQ-034 Reset release, imem_req_ready=1, rsp latency 1, instr_ready=1 -> instr_pc sequence 0,4,8,C with instr = memory words.
REQ-035 instr_ready=0 for 10 cycles -> exactly BUF_DEPTH requests issued, instr/instr_pc stable, then drains in order.
REQ-036 Redirect to 32'h100 with 2 in flight -> both responses dropped, next delivered instr_pc=32'h100.
REQ-037 Redirect same cycle as delivery handshake and response arrival -> no duplicate or stale instruction delivered.
REQ-038 Start at RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 Macro on, redirect_pc=32'h102 -> fault=1 next cycle, no further requests; n_reset pulse clears fault.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: control state encoding,
// the 32-bit machine word and the PC stepping helpers.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef logic [31:0] word_t;

    localparam word_t PC_INC = 32'd4;

    // Sequential fetch address; wraps naturally from 32'hFFFF_FFFC to 0.
    function automatic word_t pc_next(input word_t pc);
        return pc + PC_INC;
    endfunction

    // Word-align a target by clearing the byte offset.
    function automatic word_t pc_align(input word_t pc);
        return pc & ~word_t'(32'h3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush. Push while full is accepted
// only together with a pop, so occupancy never exceeds DEPTH.
// Storage is not reset; only pointers and occupancy are.
module fetch_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the buffer in one edge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response
// buffering with PC tagging, redirect flush with in-flight response drop.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds the fault port and a
// sticky FAULT state on a misaligned redirect target.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC  = 32'h0000_0000,
    parameter int    BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fault
`endif
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    state_t        state;
    state_t        state_nxt;
    logic          run_en;
    logic          fault_st;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] out_cnt_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   occ;
    logic          credit_ok;
    word_t         req_addr;
    word_t         rsp_pc;
    word_t         tgt_pc;
    logic          misalign;
    logic          req_hs;
    logic          dlv_hs;
    logic          redir;
    logic          rsp_keep;
    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [63:0]   fifo_wdata;
    logic [63:0]   fifo_rdata;

    assign tgt_pc = pc_align(redirect_pc);
`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign = (redirect_pc[1:0] != 2'b00);
    assign fault    = fault_st;
`else
    assign misalign = 1'b0;
`endif

    // Control state register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= RESET;
        else          state <= state_nxt;
    end

    // Next-state: leave RESET on the first edge, FAULT is left only by reset.
    always_comb begin
        state_nxt = state;
        case (state)
            RESET:   state_nxt = RUN;
            RUN:     if (redirect && misalign) state_nxt = FAULT;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = RESET;
        endcase
    end

    // State decode.
    always_comb begin
        run_en   = (state == RUN);
        fault_st = (state == FAULT);
    end

    // Credit: requests in flight plus buffered entries must stay below depth.
    always_comb begin
        occ = {1'b0, out_cnt} + {1'b0, fifo_cnt};
    end

    assign credit_ok      = (occ < (CW+1)'(BUF_DEPTH));
    assign imem_req_valid = run_en && credit_ok;
    assign imem_req_addr  = req_addr;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign instr_valid    = !fifo_empty && !fault_st;
    assign dlv_hs         = instr_valid && instr_ready;
    assign redir          = redirect && run_en;
    // A response is kept only if it belongs to the current stream.
    assign rsp_keep       = imem_rsp_valid && (drop_cnt == '0) && !redir;
    assign fifo_push      = rsp_keep && (!fifo_full || dlv_hs);
    assign fifo_wdata     = {rsp_pc, imem_rsp_data};
    assign instr          = fifo_empty ? '0 : fifo_rdata[31:0];
    assign instr_pc       = fifo_empty ? '0 : fifo_rdata[63:32];

    // Outstanding count after this edge; also the drop load on redirect.
    always_comb begin
        out_cnt_nxt = out_cnt;
        if (req_hs && !imem_rsp_valid)      out_cnt_nxt = out_cnt + CW'(1);
        else if (!req_hs && imem_rsp_valid) out_cnt_nxt = out_cnt - CW'(1);
    end

    // Counters and the request/response PC trackers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            out_cnt  <= '0;
            drop_cnt <= '0;
            req_addr <= RESET_PC;
            rsp_pc   <= RESET_PC;
        end else begin
            out_cnt <= out_cnt_nxt;
            if (redir)                                  drop_cnt <= out_cnt_nxt;
            else if (imem_rsp_valid && drop_cnt != '0)  drop_cnt <= drop_cnt - CW'(1);
            if (redir)       req_addr <= tgt_pc;
            else if (req_hs) req_addr <= pc_next(req_addr);
            if (redir)         rsp_pc <= tgt_pc;
            else if (rsp_keep) rsp_pc <= pc_next(rsp_pc);
        end
    end

    fetch_fifo #(
        .DATA_W (64),
        .DEPTH  (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (fifo_push),
        .pop     (dlv_hs),
        .flush   (redir),
        .wdata   (fifo_wdata),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: instruction memory model with adjustable latency and
// request budget, scoreboard queue of hand-computed {pc, instr} pairs checked
// by an independent delivery monitor, plus a second instance at a high reset PC.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        n_reset2;
    logic        req2_valid;
    logic        req2_ready;
    logic [31:0] req2_addr;
    logic        rsp2_valid;
    logic [31:0] rsp2_data;
    logic        instr2_valid;
    logic        instr2_ready;
    logic [31:0] instr2, instr2_pc;
    logic        redirect2;
    logic [31:0] redirect2_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fault, fault2;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
        .clk(clk), .n_reset(n_reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        , .fault(fault)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_dut2 (
        .clk(clk), .n_reset(n_reset2),
        .imem_req_valid(req2_valid), .imem_req_ready(req2_ready),
        .imem_req_addr(req2_addr),
        .imem_rsp_valid(rsp2_valid), .imem_rsp_data(rsp2_data),
        .instr_valid(instr2_valid), .instr_ready(instr2_ready),
        .instr(instr2), .instr_pc(instr2_pc),
        .redirect(redirect2), .redirect_pc(redirect2_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        , .fault(fault2)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [63:0] expq[$];
    logic [31:0] d2log[$];
    int          cyc    = 0;
    int          lat    = 1;
    int          budget = 0;
    int          nreq   = 0;
    logic        hs2    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic exp_push(input logic [31:0] pc, input logic [31:0] word);
        expq.push_back({pc, word});
    endtask

    task automatic wait_drain(input int maxc, input string nm);
        int i;
        i = 0;
        while (expq.size() != 0 && i < maxc) begin
            @(negedge clk);
            #3;
            i++;
        end
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d instrs still expected, required 0", nm, expq.size());
            expq.delete();
        end
    endtask

    // Instruction memory: word = addr ^ 32'h1300_0013, returned after 'lat' cycles.
    initial begin
        pend_t p;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!n_reset) begin
                pend.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
                imem_req_ready = 1'b0;
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = pend[0].addr ^ 32'h1300_0013;
                    void'(pend.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = '0;
                end
                imem_req_ready = (budget > 0);
                if (imem_req_valid && imem_req_ready) begin
                    p.addr = imem_req_addr;
                    p.due  = cyc + lat;
                    pend.push_back(p);
                    budget--;
                    nreq++;
                end
            end
            cyc++;
        end
    end

    // Delivery monitor: every handshake must match the scoreboard head.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (n_reset && instr_valid && instr_ready) begin
                if (expq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc %h instr %h, required no delivery", instr_pc, instr);
                end else begin
                    e = expq.pop_front();
                    chk("sb_pc", instr_pc, e[63:32]);
                    chk("sb_instr", instr, e[31:0]);
                end
            end
        end
    end

    // Second instance: always-ready memory with one-cycle latency, logs first addresses.
    initial begin
        req2_ready   = 1'b1;
        instr2_ready = 1'b1;
        redirect2    = 1'b0;
        redirect2_pc = '0;
        rsp2_valid   = 1'b0;
        rsp2_data    = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!n_reset2) begin
                rsp2_valid = 1'b0;
                hs2 = 1'b0;
            end else begin
                rsp2_valid = hs2;
                rsp2_data  = 32'h0000_0013;
                hs2 = req2_valid && req2_ready;
                if (hs2 && d2log.size() < 3) d2log.push_back(req2_addr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int i;
        n_reset     = 1'b0;
        n_reset2    = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_addr", imem_req_addr, 32'h0);

        // Straight-line fetch, latency 1
        @(negedge clk);
        n_reset  = 1'b1;
        n_reset2 = 1'b1;
        lat = 1;
        instr_ready = 1'b1;
        exp_push(32'h0000_0000, 32'h1300_0013);
        exp_push(32'h0000_0004, 32'h1300_0017);
        exp_push(32'h0000_0008, 32'h1300_001B);
        exp_push(32'h0000_000C, 32'h1300_001F);
        budget = 4;
        wait_drain(40, "seq");
        repeat (3) @(negedge clk);

        // Consumer stall: exactly BUF_DEPTH requests, head held stable
        instr_ready = 1'b0;
        base = nreq;
        budget = 10;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #2;
            if (instr_valid) begin
                chk("stall_pc", instr_pc, 32'h0000_0010);
                chk("stall_instr", instr, 32'h1300_0003);
            end
        end
        chk("stall_reqs", 32'(nreq - base), 32'd2);
        chk("stall_valid", {31'b0, instr_valid}, 32'h1);
        budget = 0;
        exp_push(32'h0000_0010, 32'h1300_0003);
        exp_push(32'h0000_0014, 32'h1300_0007);
        @(negedge clk);
        instr_ready = 1'b1;
        wait_drain(20, "stall_drain");

        // Redirect with two requests in flight
        repeat (2) @(negedge clk);
        lat = 3;
        exp_push(32'h0000_0100, 32'h1300_0113);
        exp_push(32'h0000_0104, 32'h1300_0117);
        budget = 2;
        i = 0;
        while (pend.size() != 2 && i < 20) begin
            @(negedge clk);
            #2;
            i++;
        end
        chk("inflight_two", 32'(pend.size()), 32'd2);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        budget = 2;
        @(negedge clk);
        redirect = 1'b0;
        wait_drain(40, "redir");

        // Redirect coinciding with delivery and a response arrival
        repeat (3) @(negedge clk);
        lat = 1;
        instr_ready = 1'b0;
        exp_push(32'h0000_0108, 32'h1300_011B);
        exp_push(32'h0000_0200, 32'h1300_0213);
        budget = 1;
        repeat (5) @(negedge clk);
        chk("hold_valid", {31'b0, instr_valid}, 32'h1);
        budget = 1;
        @(negedge clk);
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        budget = 1;
        @(negedge clk);
        redirect = 1'b0;
        wait_drain(20, "redir_dlv");
        repeat (4) @(negedge clk);

        // Reset mid-operation abandons in-flight requests
        lat = 3;
        instr_ready = 1'b0;
        budget = 2;
        repeat (3) @(negedge clk);
        n_reset = 1'b0;
        budget = 0;
        #1;
        chk("mid_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("mid_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("mid_addr", imem_req_addr, 32'h0);
        chk("mid_instr_pc", instr_pc, 32'h0);
        repeat (2) @(negedge clk);
        lat = 1;
        instr_ready = 1'b1;
        exp_push(32'h0000_0000, 32'h1300_0013);
        exp_push(32'h0000_0004, 32'h1300_0017);
        budget = 2;
        n_reset = 1'b1;
        wait_drain(30, "post_rst");

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned redirect: sticky fault, fetch halts, reset clears
        repeat (3) @(negedge clk);
        chk("pre_fault", {31'b0, fault}, 32'h0);
        base = nreq;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        @(negedge clk);
        redirect = 1'b0;
        budget = 4;
        #2;
        chk("fault_set", {31'b0, fault}, 32'h1);
        chk("fault_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("fault_instr_valid", {31'b0, instr_valid}, 32'h0);
        repeat (5) @(negedge clk);
        chk("fault_sticky", {31'b0, fault}, 32'h1);
        chk("fault_noreq", 32'(nreq - base), 32'd0);
        n_reset = 1'b0;
        budget = 0;
        #1;
        chk("fault_clear", {31'b0, fault}, 32'h0);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
`endif

        // High reset PC wraps through zero
        chk("wrap_count", 32'(d2log.size()), 32'd3);
        if (d2log.size() == 3) begin
            chk("wrap_addr0", d2log[0], 32'hFFFF_FFF8);
            chk("wrap_addr1", d2log[1], 32'hFFFF_FFFC);
            chk("wrap_addr2", d2log[2], 32'h0000_0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
